fpu_result_queue: RTL

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

---
 rtl/fpu_result_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/fpu_result_queue.sv
// Result queue between the FP add/sub stage and its consumer: DEPTH-entry FIFO of
// {fp16 result, condition codes}, optional sticky flags under FPU_STICKY_FLAGS_EN.
module fpu_result_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [15:0]              inResult,
    input  logic [3:0]               inCond,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [15:0]              outResult,
    output logic [3:0]               outCond,
    input  logic                     flush,
    input  logic                     clearFlags,
    output logic [3:0]               stickyFlags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [15:0]   mem_result [DEPTH];
    logic [3:0]    mem_cond   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          accept;

    // Status depends only on registered count, so inReady never sees outReady.
    always_comb begin
        full     = (count == FULL_COUNT);
        empty    = (count == '0);
        inReady  = ~full;
        outValid = ~empty;
        push     = inValid & inReady;
        pop      = outValid & outReady;
        accept   = push & ~flush;
    end

    always_comb begin
        outResult = '0;
        outCond   = '0;
        if (!empty) begin
            outResult = mem_result[rd_ptr];
            outCond   = mem_cond[rd_ptr];
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_result[wr_ptr] <= inResult;
            mem_cond[wr_ptr]   <= inCond;
        end
    end

    // Power-of-two DEPTH lets the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    logic [3:0] sticky;

    // Clear is applied before the merge, so clear+push leaves exactly inCond.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky <= '0;
        end else if (accept) begin
            sticky <= (clearFlags ? 4'b0000 : sticky) | inCond;
        end else if (clearFlags) begin
            sticky <= '0;
        end
    end

    assign stickyFlags = sticky;
`else
    logic unused_clear_flags;

    assign unused_clear_flags = clearFlags;
    assign stickyFlags        = '0;
`endif

endmodule
